// File: rtl/handshake_seq_checker.sv
// -----------------------------------------------------------------------------
// handshake_seq_checker
//
// Sink side of a valid/ready stream. It accepts beats from an upstream
// source, checks that the data follows an incrementing sequence starting at
// START_VAL, and checks that the source keeps valid and data stable while
// it is being stalled. The run ends when the beat expected to carry END_VAL
// is accepted.
//
// State table:
//   state | meaning
//   IDLE  | one cycle after reset release; ready held low
//   RUN   | accepting beats, sequence and hold checks active
//   DONE  | END_VAL beat accepted; terminal until reset
//
// Ports:
//   clk             in   single clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   random_stall    in   1 = withhold ready on the following cycle
//   valid_i         in   upstream valid
//   data_i          in   upstream data [DATA_W]
//   ready_o         out  registered ready to upstream
//   done_o          out  END_VAL beat has been accepted
//   pass_o          out  done_o with both error counters at zero
//   seq_err_cnt_o   out  accepted beats whose data was not the expected value
//   proto_err_cnt_o out  upstream hold-rule violations
//   xfer_cnt_o      out  accepted beats
// -----------------------------------------------------------------------------
module handshake_seq_checker #(
  parameter int DATA_W    = 8,
  parameter int START_VAL = 1,
  parameter int END_VAL   = 200,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              random_stall,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  seq_err_cnt_o,
  output logic [CNT_W-1:0]  proto_err_cnt_o,
  output logic [CNT_W-1:0]  xfer_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] START_V = DATA_W'(START_VAL);
  localparam logic [DATA_W-1:0] END_V   = DATA_W'(END_VAL);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  seq_err_q, seq_err_d;
  logic [CNT_W-1:0]  proto_err_q, proto_err_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;

  logic              xfer;
  logic              seq_hit;
  logic              proto_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    seq_err_d   = seq_err_q;
    proto_err_d = proto_err_q;
    xfer_d      = xfer_q;
    xfer        = 1'b0;
    seq_hit     = 1'b0;
    proto_hit   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        hold_d  = 1'b0;
      end

      RUN: begin
        xfer      = valid_i && ready_q;
        seq_hit   = xfer && (data_i != exp_q);
        proto_hit = hold_q && (!valid_i || (data_i != hold_data_q));

        if (xfer) begin
          // exp advances on every beat, right or wrong; no resync to data.
          exp_d  = exp_q + DATA_W'(1);
          xfer_d = sat_inc(xfer_q);
          if (exp_q == END_V) begin
            state_d = DONE;
          end
        end

        // A stalled beat (valid without ready) arms the hold check with the
        // data seen this cycle; a changed value re-arms with the new data so
        // each change is counted once.
        if (xfer || !valid_i) begin
          hold_d = 1'b0;
        end else begin
          hold_d      = 1'b1;
          hold_data_d = data_i;
        end

        if (seq_hit) begin
          seq_err_d = sat_inc(seq_err_q);
        end
        if (proto_hit) begin
          proto_err_d = sat_inc(proto_err_q);
        end
      end

      DONE: begin
        hold_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == RUN) && !random_stall;
    done_d  = (state_d == DONE);
    // Built from next-state counts so pass lines up with done on the same cycle.
    pass_d  = done_d && (seq_err_d == '0) && (proto_err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= START_V;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      seq_err_q   <= '0;
      proto_err_q <= '0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      seq_err_q   <= seq_err_d;
      proto_err_q <= proto_err_d;
      xfer_q      <= xfer_d;
    end
  end

  assign ready_o         = ready_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign seq_err_cnt_o   = seq_err_q;
  assign proto_err_cnt_o = proto_err_q;
  assign xfer_cnt_o      = xfer_q;

endmodule

// File: tb/tb_handshake_seq_checker.sv
// -----------------------------------------------------------------------------
// Bench for handshake_seq_checker. Three instances with different parameter
// sets share clock and reset; each cycle a behavioural model predicts every
// output of every instance from counts of accepted beats.
// -----------------------------------------------------------------------------
module tb_handshake_seq_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // instance 0: defaults
  logic        s0, v0;
  logic [7:0]  d0;
  logic        rdy0, done0, pass0;
  logic [15:0] seq0, proto0, xfer0;
  // instance 1: narrow data with wrap
  logic        s1, v1;
  logic [3:0]  d1;
  logic        rdy1, done1, pass1;
  logic [15:0] seq1, proto1, xfer1;
  // instance 2: narrow counters
  logic        s2, v2;
  logic [7:0]  d2;
  logic        rdy2, done2, pass2;
  logic [2:0]  seq2, proto2, xfer2;

  handshake_seq_checker dut0 (
    .clk(clk), .rst_n(rst_n), .random_stall(s0), .valid_i(v0), .data_i(d0),
    .ready_o(rdy0), .done_o(done0), .pass_o(pass0),
    .seq_err_cnt_o(seq0), .proto_err_cnt_o(proto0), .xfer_cnt_o(xfer0));

  handshake_seq_checker #(.DATA_W(4), .START_VAL(14), .END_VAL(2), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .random_stall(s1), .valid_i(v1), .data_i(d1),
    .ready_o(rdy1), .done_o(done1), .pass_o(pass1),
    .seq_err_cnt_o(seq1), .proto_err_cnt_o(proto1), .xfer_cnt_o(xfer1));

  handshake_seq_checker #(.DATA_W(8), .START_VAL(1), .END_VAL(20), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .random_stall(s2), .valid_i(v2), .data_i(d2),
    .ready_o(rdy2), .done_o(done2), .pass_o(pass2),
    .seq_err_cnt_o(seq2), .proto_err_cnt_o(proto2), .xfer_cnt_o(xfer2));

  logic [31:0] o_rdy [3];
  logic [31:0] o_done [3];
  logic [31:0] o_pass [3];
  logic [31:0] o_seq [3];
  logic [31:0] o_proto [3];
  logic [31:0] o_xfer [3];

  assign o_rdy[0] = {31'b0, rdy0};   assign o_rdy[1] = {31'b0, rdy1};   assign o_rdy[2] = {31'b0, rdy2};
  assign o_done[0] = {31'b0, done0}; assign o_done[1] = {31'b0, done1}; assign o_done[2] = {31'b0, done2};
  assign o_pass[0] = {31'b0, pass0}; assign o_pass[1] = {31'b0, pass1}; assign o_pass[2] = {31'b0, pass2};
  assign o_seq[0] = {16'b0, seq0};   assign o_seq[1] = {16'b0, seq1};   assign o_seq[2] = {29'b0, seq2};
  assign o_proto[0] = {16'b0, proto0}; assign o_proto[1] = {16'b0, proto1}; assign o_proto[2] = {29'b0, proto2};
  assign o_xfer[0] = {16'b0, xfer0}; assign o_xfer[1] = {16'b0, xfer1}; assign o_xfer[2] = {29'b0, xfer2};

  // instance parameters as the model sees them
  int p_w [3]     = '{8, 4, 8};
  int p_start [3] = '{1, 14, 1};
  int p_end [3]   = '{200, 2, 20};
  int p_cmax [3]  = '{65535, 65535, 7};

  // stimulus for the coming edge
  bit iv [3];
  int idat [3];
  bit is [3];

  // model: raw (unsaturated) counts plus handshake bookkeeping
  bit m_started [3];
  bit m_done [3];
  bit m_ready [3];
  bit m_hold [3];
  int m_hold_data [3];
  int m_seq [3];
  int m_proto [3];
  int m_xfer [3];
  bit m_xf [3];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_started[i] = 0; m_done[i] = 0; m_ready[i] = 0; m_hold[i] = 0;
      m_hold_data[i] = 0; m_seq[i] = 0; m_proto[i] = 0; m_xfer[i] = 0; m_xf[i] = 0;
    end
  endtask

  // What one rising edge does to instance id, from the handshake rules.
  task automatic model_edge(input int id);
    int mask, d, e;
    bit xf;
    mask = (1 << p_w[id]) - 1;
    d = idat[id] & mask;
    m_xf[id] = 0;
    if (!m_started[id]) begin
      m_started[id] = 1;
      m_ready[id] = !is[id];
      m_hold[id] = 0;
      return;
    end
    if (m_done[id]) begin
      m_ready[id] = 0;
      m_hold[id] = 0;
      return;
    end
    xf = iv[id] && m_ready[id];
    e = (p_start[id] + m_xfer[id]) & mask;
    if (m_hold[id] && (!iv[id] || d != m_hold_data[id])) m_proto[id]++;
    if (xf) begin
      if (d != e) m_seq[id]++;
      m_xfer[id]++;
      if (e == p_end[id]) m_done[id] = 1;
    end
    if (xf || !iv[id]) m_hold[id] = 0;
    else begin
      m_hold[id] = 1;
      m_hold_data[id] = d;
    end
    m_ready[id] = !m_done[id] && !is[id];
    m_xf[id] = xf;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), o_rdy[i], 32'(m_ready[i]));
      chk($sformatf("done%0d", i), o_done[i], 32'(m_done[i]));
      chk($sformatf("pass%0d", i), o_pass[i], 32'(m_done[i] && m_seq[i] == 0 && m_proto[i] == 0));
      chk($sformatf("seq%0d", i), o_seq[i], 32'(sat(m_seq[i], p_cmax[i])));
      chk($sformatf("proto%0d", i), o_proto[i], 32'(sat(m_proto[i], p_cmax[i])));
      chk($sformatf("xfer%0d", i), o_xfer[i], 32'(sat(m_xfer[i], p_cmax[i])));
    end
  endtask

  // Called at a falling edge: apply stimulus, predict the edge, check after it.
  task automatic tick();
    s0 = is[0]; v0 = iv[0]; d0 = 8'(idat[0]);
    s1 = is[1]; v1 = iv[1]; d1 = 4'(idat[1]);
    s2 = is[2]; v2 = iv[2]; d2 = 8'(idat[2]);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) model_edge(i);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic step0(input bit v, input int d, input bit s);
    iv[0] = v; idat[0] = d; is[0] = s;
    tick();
  endtask

  // Asynchronous reset pulse dly time units after the current falling edge.
  task automatic reset_pulse(input int dly);
    #dly;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; is[i] = 0; idat[i] = 0;
    end
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // mode 0: correct sequence, 1: value START+4 skipped, 2: all zeros.
  // rnd: random valid (held until accepted) and random stall.
  task automatic run(input int id, input int mode, input bit rnd, input int max_xfer, input int budget);
    int cyc;
    bit hv;
    int k, val;
    cyc = 0;
    hv = 0;
    while (!m_done[id] && m_xfer[id] < max_xfer && cyc < budget) begin
      k = m_xfer[id];
      val = p_start[id] + k;
      if (mode == 1 && k >= 4) val++;
      if (mode == 2) val = 0;
      val = val & ((1 << p_w[id]) - 1);
      if (rnd) begin
        if (!hv) hv = 1'($urandom_range(0, 1));
        is[id] = 1'($urandom_range(0, 1));
      end else begin
        hv = 1;
        is[id] = 0;
      end
      iv[id] = hv;
      idat[id] = val;
      tick();
      cyc++;
      if (m_xf[id]) hv = 0;
    end
    iv[id] = 0;
    is[id] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; is[i] = 0; idat[i] = 0;
    end
    s0 = 0; v0 = 0; d0 = 0;
    s1 = 0; v1 = 0; d1 = 0;
    s2 = 0; v2 = 0; d2 = 0;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // back-to-back 1..200, no stalls
    run(0, 0, 0, 1000, 1000);
    chk("s1_done", o_done[0], 1);
    chk("s1_xfer", o_xfer[0], 200);
    chk("s1_pass", o_pass[0], 1);
    tick();
    chk("s1_ready_after", o_rdy[0], 0);

    // reset mid-run after 50 beats, then a full randomized rerun
    reset_pulse(2);
    run(0, 0, 0, 50, 500);
    chk("s6_xfer50", o_xfer[0], 50);
    reset_pulse(3);
    chk("s6_xfer_cleared", o_xfer[0], 0);
    chk("s6_ready_low", o_rdy[0], 0);
    run(0, 0, 1, 1000, 5000);
    chk("s2_done", o_done[0], 1);
    chk("s2_xfer", o_xfer[0], 200);
    chk("s2_seq", o_seq[0], 0);
    chk("s2_proto", o_proto[0], 0);
    chk("s2_pass", o_pass[0], 1);

    // value 5 skipped
    reset_pulse(2);
    run(0, 1, 0, 1000, 1000);
    chk("s3_done", o_done[0], 1);
    chk("s3_seq", o_seq[0], 196);
    chk("s3_pass", o_pass[0], 0);

    // data changes from 7 to 8 while stalled
    reset_pulse(2);
    step0(0, 0, 0);
    for (int k = 1; k <= 5; k++) step0(1, k, 0);
    step0(1, 6, 1);
    step0(1, 7, 1);
    step0(1, 8, 0);
    step0(1, 8, 0);
    step0(0, 0, 0);
    chk("s4_proto", o_proto[0], 1);
    chk("s4_seq", o_seq[0], 1);
    chk("s4_xfer", o_xfer[0], 7);

    // valid dropped while stalled
    reset_pulse(2);
    step0(0, 0, 0);
    step0(1, 1, 0);
    step0(1, 2, 1);
    step0(1, 3, 1);
    step0(0, 0, 0);
    step0(1, 3, 0);
    step0(0, 0, 0);
    chk("s5_proto", o_proto[0], 1);
    chk("s5_seq", o_seq[0], 0);
    chk("s5_xfer", o_xfer[0], 3);

    // 4-bit data, 14,15,0,1,2
    run(1, 0, 0, 100, 100);
    chk("w4_done", o_done[1], 1);
    chk("w4_xfer", o_xfer[1], 5);
    chk("w4_seq", o_seq[1], 0);
    chk("w4_pass", o_pass[1], 1);

    // 3-bit counters, 20 mismatches
    run(2, 2, 0, 100, 200);
    chk("c3_done", o_done[2], 1);
    chk("c3_seq_sat", o_seq[2], 7);
    chk("c3_xfer_sat", o_xfer[2], 7);
    chk("c3_pass", o_pass[2], 0);
    tick();
    chk("c3_seq_hold", o_seq[2], 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
